radix2_online_block_adder: RTL and testbench
============================================

Name: radix2_online_block_adder

Overview:
- Block-serial online adder for radix-2 signed-digit (borrow-save, p/n) operands.
- Operands stream MSB block first, NO_OF_DIGITS digits per beat.
- Carry-free: a block's outgoing transfer never depends on its own carry-in, so each output block is emitted one block after its input (online delay = 1 block).
- Sits between digit-serial online operators in the datapath; adds framing, backpressure and a leading overflow digit.

Parameters:
- NO_OF_DIGITS, 8, digits per block (≥2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_first  in  1  beat is the frame's MSB block
- in_last  in  1  beat is the frame's LSB block
- din1p, din1n, din2p, din2n  in  NO_OF_DIGITS each  operand digits; digit value = p − n
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_first, out_last  out  1 each  framing, aligned to output blocks
- doutp, doutn  out  NO_OF_DIGITS each  sum block digits
- ovfp, ovfn  out  1 each  frame overflow digit at weight 2^(k·nblocks); meaningful only with out_first
- proto_err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset: all outputs 0; in_ready 1; state IDLE.
- Core cell, combinational, per digit i:
  - fa1: p1 + ~n1 + p2 → (c1, s1).
  - fa2: s1 + c1[i−1] + ~n2 → (c2, s2); for i = 0 the carry-in is cin.
- Core outputs:
  - doutp = s2.
  - doutn[i] = ~c2[i−1] for i ≥ 1.
  - doutn[0] = tn_in.
  - Block transfer t = (tp = c1[k−1], tn = ~c2[k−1]), value tp − tn. The top fa1 carry is kept, never dropped.
- Block identity: X + Y + tp_in − tn_in = D + t·2^k.
- Finalising block j: cin = tp of block j+1, doutn[0] = tn of block j+1. After a frame's last block, t_in = 0.
- Hold register H stores the raw operand block, its first flag, and the frame transfer when first.
- Output is a one-deep register O. in_ready = (state ≠ FLUSH) & (!out_valid | out_ready).
- States:
  - IDLE: H empty. On accept, H ← beat. If in_first, latch ovf ← t(beat). Go to FLUSH if in_last, else HOLD. No output.
  - HOLD: on accept, O ← finalise(H, t(beat)) with out_first = H.first; H ← beat. Go to FLUSH if in_last.
  - FLUSH: in_ready = 0. When the O slot is free, O ← finalise(H, 0) with out_last = 1; go to IDLE.
- Single-block frame: out_first and out_last assert on the same beat.
- Each block yields exactly one output beat.
- Output of block j is registered: out_valid rises the cycle after block j+1 (or the flush) is accepted.
- With out_ready held at 1, throughput is 1 block/cycle plus 1 flush cycle per frame.
- Backpressure: O and all flags hold stable while out_valid & !out_ready.
- in_valid low in HOLD: nothing emitted; H is retained indefinitely.
- Asserting rst_n mid-frame discards H and O; out_valid falls asynchronously.
- in_first in HOLD is treated as a continuation, and ovf is not overwritten.
- Input p = n = 1 is a legal zero digit.

Optional Feature:
- Macro R2OLA_PROTOCOL_CHK_EN.
- Defined: proto_err is set (sticky until reset) on either condition:
  - an accepted beat in IDLE without in_first;
  - an accepted beat with in_first while in HOLD.
- Not defined: proto_err is tied to 0; no check logic.

Decomposition:
- Package r2ola_pkg holds:
  - state enum {IDLE, HOLD, FLUSH};
  - signed-digit block struct (p, n vectors);
  - transfer struct (tp, tn).
- Sub-module r2ola_block_core: pure combinational two-level FA block. Inputs: operands, cin, tn_in. Outputs: doutp, doutn, tp, tn. Instantiated twice:
  - on the incoming beat, to compute its transfer;
  - on H, to finalise.

Test Plan (k = 4; value of a beat = Σ(p−n)·2^i; check ovf·2^(4n) + Σ blocks = X + Y):
- Two-block frame, X = Y = all-+1 (255 each) -> 2 output beats, reconstructed value 510, first beat carries ovf and out_first, last beat carries out_last.
- Two-block frame, X = all-−1 (−255), Y = all-+1 (+255) -> reconstructed 0, every output digit value in {−1, 0, 1}.
- Single-block frame, X = 0b0111 (p), Y = 0b0001 (p), value 8 -> one beat with out_first & out_last, ovf·16 + D = 8.
- Four-block frame, random X/Y, out_ready toggled 1,0,0,1 -> no lost or duplicated beat, outputs stable while stalled, sum correct.
- Mid-frame reset after 2 of 4 blocks, then a fresh 1-block frame X = Y = 1 -> out_valid 0 during reset, new frame result 2, no stale beat emitted.
- With R2OLA_PROTOCOL_CHK_EN: beat without in_first in IDLE -> proto_err 1 next cycle and held until rst_n low.

Source files
------------

// File: rtl/r2ola_pkg.sv
`default_nettype none
// ============================================================================
// Module  : r2ola_pkg
// Brief   : Shared types and full-adder helpers for the radix-2 online
//           block adder (state encoding, signed-digit block, block transfer).
// Revision: 1.0 - initial release
// ============================================================================
package r2ola_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int unsigned R2OLA_DEFAULT_DIGITS = 8;

    // Borrow-save block: digit value = p - n, one bit pair per digit.
    typedef struct packed {
        logic [R2OLA_DEFAULT_DIGITS-1:0] p;
        logic [R2OLA_DEFAULT_DIGITS-1:0] n;
    } sd_block_t;

    typedef struct packed {
        logic tp;
        logic tn;
    } transfer_t;

    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage : r2ola_pkg
`default_nettype wire

// File: rtl/r2ola_block_core.sv
`default_nettype none
// ============================================================================
// Module  : r2ola_block_core
// Brief   : Combinational two-level full-adder block for borrow-save addition;
//           the outgoing transfer (tp, tn) is independent of cin and tn_in.
// Revision: 1.0 - initial release
// ============================================================================
module r2ola_block_core
    import r2ola_pkg::*;
#(
    parameter int NO_OF_DIGITS = 8
) (
    input  logic [NO_OF_DIGITS-1:0] x_p,
    input  logic [NO_OF_DIGITS-1:0] x_n,
    input  logic [NO_OF_DIGITS-1:0] y_p,
    input  logic [NO_OF_DIGITS-1:0] y_n,
    input  logic                    cin,
    input  logic                    tn_in,
    output logic [NO_OF_DIGITS-1:0] doutp,
    output logic [NO_OF_DIGITS-1:0] doutn,
    output logic                    tp,
    output logic                    tn
);

    logic [NO_OF_DIGITS-1:0] w_s1;
    logic [NO_OF_DIGITS-1:0] w_c1;
    logic [NO_OF_DIGITS-1:0] w_s2;
    logic [NO_OF_DIGITS-1:0] w_c2;
    logic [NO_OF_DIGITS-1:0] w_c2_in;

    // Second-level carry-in: the first-level carry of the digit below.
    assign w_c2_in = {w_c1[NO_OF_DIGITS-2:0], cin};

    genvar gi;
    for (gi = 0; gi < NO_OF_DIGITS; gi++) begin : g_digit
        assign w_s1[gi] = fa_sum  (x_p[gi], ~x_n[gi], y_p[gi]);
        assign w_c1[gi] = fa_carry(x_p[gi], ~x_n[gi], y_p[gi]);
        assign w_s2[gi] = fa_sum  (w_s1[gi], w_c2_in[gi], ~y_n[gi]);
        assign w_c2[gi] = fa_carry(w_s1[gi], w_c2_in[gi], ~y_n[gi]);
    end

    assign doutp = w_s2;
    assign doutn = {~w_c2[NO_OF_DIGITS-2:0], tn_in};
    assign tp    = w_c1[NO_OF_DIGITS-1];
    assign tn    = ~w_c2[NO_OF_DIGITS-1];

endmodule : r2ola_block_core
`default_nettype wire

// File: rtl/radix2_online_block_adder.sv
`default_nettype none
// ============================================================================
// Module  : radix2_online_block_adder
// Brief   : Block-serial online adder for radix-2 borrow-save operands, MSB
//           block first, one block of online delay, registered output stage.
//           Optional macro R2OLA_PROTOCOL_CHK_EN enables the sticky proto_err.
// Revision: 1.0 - initial release
// ============================================================================
module radix2_online_block_adder
    import r2ola_pkg::*;
#(
    parameter int NO_OF_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [NO_OF_DIGITS-1:0] din1p,
    input  logic [NO_OF_DIGITS-1:0] din1n,
    input  logic [NO_OF_DIGITS-1:0] din2p,
    input  logic [NO_OF_DIGITS-1:0] din2n,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_first,
    output logic                    out_last,
    output logic [NO_OF_DIGITS-1:0] doutp,
    output logic [NO_OF_DIGITS-1:0] doutn,
    output logic                    ovfp,
    output logic                    ovfn,
    output logic                    proto_err
);

    state_e                  r_state;
    logic [NO_OF_DIGITS-1:0] r_h_x_p;
    logic [NO_OF_DIGITS-1:0] r_h_x_n;
    logic [NO_OF_DIGITS-1:0] r_h_y_p;
    logic [NO_OF_DIGITS-1:0] r_h_y_n;
    logic                    r_h_first;
    transfer_t               r_ovf;

    logic                    w_accept;
    logic                    w_slot_free;
    logic                    w_emit;
    logic                    w_beat_tp;
    logic                    w_beat_tn;
    transfer_t               w_beat_t;
    transfer_t               w_fin_t;
    logic [NO_OF_DIGITS-1:0] w_fin_doutp;
    logic [NO_OF_DIGITS-1:0] w_fin_doutn;
    logic                    unused_fin_tp;
    logic                    unused_fin_tn;
    logic [NO_OF_DIGITS-1:0] unused_beat_doutp;
    logic [NO_OF_DIGITS-1:0] unused_beat_doutn;

    assign w_slot_free = !out_valid | out_ready;
    assign in_ready    = (r_state != FLUSH) & w_slot_free;
    assign w_accept    = in_valid & in_ready;
    assign w_emit      = ((r_state == HOLD) & w_accept) | ((r_state == FLUSH) & w_slot_free);

    // Transfer of the incoming beat; its sum digits are never needed.
    r2ola_block_core #(
        .NO_OF_DIGITS (NO_OF_DIGITS)
    ) u_beat_core (
        .x_p   (din1p),
        .x_n   (din1n),
        .y_p   (din2p),
        .y_n   (din2n),
        .cin   (1'b0),
        .tn_in (1'b0),
        .doutp (unused_beat_doutp),
        .doutn (unused_beat_doutn),
        .tp    (w_beat_tp),
        .tn    (w_beat_tn)
    );

    assign w_beat_t.tp = w_beat_tp;
    assign w_beat_t.tn = w_beat_tn;

    // After the frame's last block nothing flows in from below.
    assign w_fin_t = (r_state == FLUSH) ? '0 : w_beat_t;

    r2ola_block_core #(
        .NO_OF_DIGITS (NO_OF_DIGITS)
    ) u_fin_core (
        .x_p   (r_h_x_p),
        .x_n   (r_h_x_n),
        .y_p   (r_h_y_p),
        .y_n   (r_h_y_n),
        .cin   (w_fin_t.tp),
        .tn_in (w_fin_t.tn),
        .doutp (w_fin_doutp),
        .doutn (w_fin_doutn),
        .tp    (unused_fin_tp),
        .tn    (unused_fin_tn)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_h_x_p   <= '0;
            r_h_x_n   <= '0;
            r_h_y_p   <= '0;
            r_h_y_n   <= '0;
            r_h_first <= 1'b0;
            r_ovf     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_h_x_p   <= din1p;
                        r_h_x_n   <= din1n;
                        r_h_y_p   <= din2p;
                        r_h_y_n   <= din2n;
                        r_h_first <= in_first;
                        if (in_first) begin
                            r_ovf <= w_beat_t;
                        end
                        r_state <= in_last ? FLUSH : HOLD;
                    end
                end
                HOLD: begin
                    // in_first mid-frame is a continuation: ovf is kept.
                    if (w_accept) begin
                        r_h_x_p   <= din1p;
                        r_h_x_n   <= din1n;
                        r_h_y_p   <= din2p;
                        r_h_y_n   <= din2n;
                        r_h_first <= 1'b0;
                        r_state   <= in_last ? FLUSH : HOLD;
                    end
                end
                FLUSH: begin
                    if (w_slot_free) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            doutp     <= '0;
            doutn     <= '0;
            ovfp      <= 1'b0;
            ovfn      <= 1'b0;
        end else if (w_emit) begin
            out_valid <= 1'b1;
            out_first <= r_h_first;
            out_last  <= (r_state == FLUSH);
            doutp     <= w_fin_doutp;
            doutn     <= w_fin_doutn;
            ovfp      <= r_h_first & r_ovf.tp;
            ovfn      <= r_h_first & r_ovf.tn;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef R2OLA_PROTOCOL_CHK_EN
    logic r_proto_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_proto_err <= 1'b0;
        end else if (w_accept && (((r_state == IDLE) && !in_first) ||
                                  ((r_state == HOLD) &&  in_first))) begin
            r_proto_err <= 1'b1;
        end
    end

    assign proto_err = r_proto_err;
`else
    assign proto_err = 1'b0;
`endif

endmodule : radix2_online_block_adder
`default_nettype wire

// File: tb/tb_radix2_online_block_adder.sv
`default_nettype none
// ============================================================================
// Module  : tb_radix2_online_block_adder
// Brief   : Directed self-checking bench with a frame scoreboard (k = 4).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_radix2_online_block_adder;

    localparam int K = 4;
`ifdef R2OLA_PROTOCOL_CHK_EN
    localparam logic EXP_PERR = 1'b1;
`else
    localparam logic EXP_PERR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_first = 1'b0;
    logic         in_last = 1'b0;
    logic [K-1:0] din1p = '0;
    logic [K-1:0] din1n = '0;
    logic [K-1:0] din2p = '0;
    logic [K-1:0] din2n = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_first;
    logic         out_last;
    logic [K-1:0] doutp;
    logic [K-1:0] doutn;
    logic         ovfp;
    logic         ovfn;
    logic         proto_err;

    always #5 clk = ~clk;

    radix2_online_block_adder #(
        .NO_OF_DIGITS (K)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .din1p     (din1p),
        .din1n     (din1n),
        .din2p     (din2p),
        .din2n     (din2n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last),
        .doutp     (doutp),
        .doutn     (doutn),
        .ovfp      (ovfp),
        .ovfn      (ovfn),
        .proto_err (proto_err)
    );

    int           checks = 0;
    int           errors = 0;
    logic [1:0]   exp_flags[$];
    longint       exp_sum[$];
    logic [K-1:0] fx1p[8];
    logic [K-1:0] fx1n[8];
    logic [K-1:0] fx2p[8];
    logic [K-1:0] fx2n[8];

    // Output monitor: framing, stall stability and frame-value reconstruction.
    longint         acc = 0;
    longint         want_sum;
    logic [1:0]     want_flags;
    logic           stalled_prev = 1'b0;
    logic [2*K+3:0] snap;

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (stalled_prev) begin
                checks++;
                assert ({doutp, doutn, out_first, out_last, ovfp, ovfn} === snap) else begin
                    errors++;
                    $error("FAIL stall_hold observed=%h expected=%h",
                           {doutp, doutn, out_first, out_last, ovfp, ovfn}, snap);
                end
            end
            if (out_ready) begin
                stalled_prev = 1'b0;
                checks++;
                assert (exp_flags.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat observed=beat expected=none");
                end
                if (exp_flags.size() > 0) begin
                    want_flags = exp_flags.pop_front();
                    checks++;
                    assert ({out_first, out_last} === want_flags) else begin
                        errors++;
                        $error("FAIL beat_flags observed=%b expected=%b", {out_first, out_last}, want_flags);
                    end
                    if (out_first) acc = longint'(ovfp) - longint'(ovfn);
                    acc = acc * 16 + (longint'(doutp) - longint'(doutn));
                    if (out_last) begin
                        want_sum = (exp_sum.size() > 0) ? exp_sum.pop_front() : 64'h7fff_ffff;
                        checks++;
                        assert (acc == want_sum) else begin
                            errors++;
                            $error("FAIL frame_sum observed=%0d expected=%0d", acc, want_sum);
                        end
                        acc = 0;
                    end
                end
            end else begin
                stalled_prev = 1'b1;
                snap = {doutp, doutn, out_first, out_last, ovfp, ovfn};
            end
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic f, input logic l, input logic [K-1:0] ap,
                             input logic [K-1:0] an, input logic [K-1:0] bp, input logic [K-1:0] bn);
        bit done = 1'b0;
        in_valid = 1'b1; in_first = f; in_last = l;
        din1p = ap; din1n = an; din2p = bp; din2n = bn;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                done = 1'b1;
            end
        end
        #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        chk("send_accept", {63'd0, done}, 64'd1);
    endtask

    task automatic send_frame(input int nb);
        longint s = 0;
        for (int j = 0; j < nb; j++) begin
            s = s * 16 + (longint'(fx1p[j]) - longint'(fx1n[j]))
                       + (longint'(fx2p[j]) - longint'(fx2n[j]));
            exp_flags.push_back({(j == 0), (j == nb - 1)});
        end
        exp_sum.push_back(s);
        for (int j = 0; j < nb; j++) begin
            send_beat((j == 0), (j == nb - 1), fx1p[j], fx1n[j], fx2p[j], fx2n[j]);
        end
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((exp_flags.size() != 0 || out_valid) && c < 200) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk("drain_empty", 64'(exp_flags.size() + exp_sum.size()), 64'd0);
    endtask

    logic [3:0] pat = 4'b1001;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_dout",      {56'd0, doutp, doutn}, 64'd0);
        chk("rst_ovf",       {62'd0, ovfp, ovfn}, 64'd0);
        chk("rst_proto_err", {63'd0, proto_err}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two blocks, X = Y = +255
        for (int j = 0; j < 2; j++) begin
            fx1p[j] = 4'hF; fx1n[j] = 4'h0; fx2p[j] = 4'hF; fx2n[j] = 4'h0;
        end
        send_frame(2);
        wait_drain();

        // Two blocks, X = -255, Y = +255
        for (int j = 0; j < 2; j++) begin
            fx1p[j] = 4'h0; fx1n[j] = 4'hF; fx2p[j] = 4'hF; fx2n[j] = 4'h0;
        end
        send_frame(2);
        wait_drain();

        // Single block 7 + 1
        fx1p[0] = 4'b0111; fx1n[0] = '0; fx2p[0] = 4'b0001; fx2n[0] = '0;
        send_frame(1);
        wait_drain();

        // Zero digits encoded as p = n = 1 mixed into a 3-block frame
        fx1p[0] = 4'hF; fx1n[0] = 4'hF; fx2p[0] = 4'hA; fx2n[0] = 4'h5;
        fx1p[1] = 4'h3; fx1n[1] = 4'hC; fx2p[1] = 4'h0; fx2n[1] = 4'hF;
        fx1p[2] = 4'h8; fx1n[2] = 4'h1; fx2p[2] = 4'h6; fx2n[2] = 4'h6;
        send_frame(3);
        wait_drain();

        // Four random blocks with out_ready pattern 1,0,0,1
        for (int j = 0; j < 4; j++) begin
            fx1p[j] = 4'($urandom); fx1n[j] = 4'($urandom);
            fx2p[j] = 4'($urandom); fx2n[j] = 4'($urandom);
        end
        fork
            send_frame(4);
            begin
                for (int c = 0; c < 24; c++) begin
                    @(posedge clk); #1;
                    out_ready = pat[c % 4];
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        chk("no_perr_legal", {63'd0, proto_err}, 64'd0);

        // Mid-frame reset after 2 of 4 blocks (nothing consumed meanwhile)
        out_ready = 1'b0;
        send_beat(1'b1, 1'b0, 4'h1, 4'h0, 4'h3, 4'h0);
        send_beat(1'b0, 1'b0, 4'h2, 4'h0, 4'h3, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {63'd0, out_valid}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_valid", {63'd0, out_valid}, 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        fx1p[0] = 4'h1; fx1n[0] = '0; fx2p[0] = 4'h1; fx2n[0] = '0;
        send_frame(1);
        wait_drain();

        // Beat without in_first in IDLE
        exp_flags.push_back(2'b01);
        exp_sum.push_back(2);
        send_beat(1'b0, 1'b1, 4'h1, 4'h0, 4'h1, 4'h0);
        chk("perr_set", {63'd0, proto_err}, {63'd0, EXP_PERR});
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        chk("perr_sticky", {63'd0, proto_err}, {63'd0, EXP_PERR});
        rst_n = 1'b0;
        #1;
        chk("perr_cleared", {63'd0, proto_err}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_radix2_online_block_adder
`default_nettype wire
